// File: rtl/ctrl_vector_seq.sv
// ctrl_vector_seq -- stored control-vector sequencer.
//
// Control vectors are written into DEPTH slots while the block is idle or
// done. A run then replays them from slot 0. Each vector takes two cycles
// (APPLY, CHECK). In step mode the block pauses after each vector until
// step is pulsed. A run ends at the first slot flagged "last", or at slot
// DEPTH-1 if no slot is flagged.
//
// Optional feature macro: CTRL_VECTOR_SEQ_COMPARE_EN.
// When it is defined, each slot also holds an expected result. That value is
// compared against dut_result on the way out of CHECK, and failures are
// counted in err_count and flagged on mismatch. When it is undefined,
// load_exp and dut_result are ignored and err_count/mismatch read zero.
// Sequencing is the same in both builds.
module ctrl_vector_seq #(
    parameter  int unsigned VEC_W = 42,
    parameter  int unsigned DEPTH = 16,
    parameter  int unsigned RES_W = 8,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             load_we,
    input  logic [AW-1:0]    load_addr,
    input  logic [VEC_W-1:0] load_vec,
    input  logic [RES_W-1:0] load_exp,
    input  logic             load_last,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step,
    input  logic [RES_W-1:0] dut_result,
    output logic [VEC_W-1:0] ctrl_out,
    output logic             ctrl_valid,
    output logic [AW-1:0]    vec_num,
    output logic [15:0]      err_count,
    output logic             mismatch,
    output logic             busy,
    output logic             done
);

    localparam logic [AW-1:0] FIRST_IDX = '0;
    localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_CHECK,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [VEC_W-1:0] vec_mem_q [DEPTH];
    logic [DEPTH-1:0] last_q;
    logic [VEC_W-1:0] ctrl_out_q;
    logic             ctrl_valid_q;
    logic [AW-1:0]    vec_num_q;
    logic [AW-1:0]    vec_num_d;
    logic             load_ok;
    logic             final_vec;

    // Storage is only writable outside a run, so a run always sees a stable table.
    assign load_ok   = Reset && load_we && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign vec_num_d = vec_num_q + AW'(1);
    // The current vector ends the run if it is flagged, or if it is the top slot.
    assign final_vec = last_q[vec_num_q] || (vec_num_q == LAST_IDX);

`ifdef CTRL_VECTOR_SEQ_COMPARE_EN
    logic [RES_W-1:0] exp_mem_q [DEPTH];
    logic [15:0]      err_count_q;
    logic [15:0]      err_count_d;
    logic             mismatch_q;
    logic             cmp_fail;

    assign cmp_fail    = (dut_result != exp_mem_q[vec_num_q]);
    assign err_count_d = (err_count_q == 16'hFFFF) ? err_count_q : err_count_q + 16'd1;

    // Expected-result storage; like the vectors, it survives reset.
    always_ff @(posedge Clock) begin
        if (load_ok) begin
            exp_mem_q[load_addr] <= load_exp;
        end
    end

    assign err_count = err_count_q;
    assign mismatch  = mismatch_q;
`else
    logic unused_compare_inputs;
    assign unused_compare_inputs = ^{load_exp, dut_result};

    assign err_count = '0;
    assign mismatch  = 1'b0;
`endif

    // Vector storage: no reset, so stored data is reusable after an abort.
    always_ff @(posedge Clock) begin
        if (load_ok) begin
            vec_mem_q[load_addr] <= load_vec;
        end
    end

    // Run sequencer: state, applied vector, index, last flags and compare status.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q      <= S_IDLE;
            ctrl_out_q   <= '0;
            ctrl_valid_q <= 1'b0;
            vec_num_q    <= '0;
            last_q       <= '0;
`ifdef CTRL_VECTOR_SEQ_COMPARE_EN
            err_count_q  <= '0;
            mismatch_q   <= 1'b0;
`endif
        end else begin
            ctrl_valid_q <= 1'b0;
`ifdef CTRL_VECTOR_SEQ_COMPARE_EN
            mismatch_q   <= 1'b0;
`endif
            case (state_q)
                S_IDLE, S_DONE: begin
                    // A load wins over start in the same cycle.
                    if (load_we) begin
                        last_q[load_addr] <= load_last;
                    end else if (start) begin
                        state_q      <= S_APPLY;
                        vec_num_q    <= FIRST_IDX;
                        ctrl_out_q   <= vec_mem_q[FIRST_IDX];
                        ctrl_valid_q <= 1'b1;
`ifdef CTRL_VECTOR_SEQ_COMPARE_EN
                        err_count_q  <= '0;
`endif
                    end
                end

                S_APPLY: begin
                    state_q <= S_CHECK;
                end

                S_CHECK: begin
`ifdef CTRL_VECTOR_SEQ_COMPARE_EN
                    if (cmp_fail) begin
                        err_count_q <= err_count_d;
                        mismatch_q  <= 1'b1;
                    end
`endif
                    if (final_vec) begin
                        state_q    <= S_DONE;
                        ctrl_out_q <= '0;
                    end else if (step_mode) begin
                        state_q <= S_PAUSE;
                    end else begin
                        state_q      <= S_APPLY;
                        vec_num_q    <= vec_num_d;
                        ctrl_out_q   <= vec_mem_q[vec_num_d];
                        ctrl_valid_q <= 1'b1;
                    end
                end

                S_PAUSE: begin
                    // Only step releases a pause; dropping step_mode here has no effect.
                    if (step) begin
                        state_q      <= S_APPLY;
                        vec_num_q    <= vec_num_d;
                        ctrl_out_q   <= vec_mem_q[vec_num_d];
                        ctrl_valid_q <= 1'b1;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ctrl_out   = ctrl_out_q;
    assign ctrl_valid = ctrl_valid_q;
    assign vec_num    = vec_num_q;
    assign busy       = (state_q == S_APPLY) || (state_q == S_CHECK) || (state_q == S_PAUSE);
    assign done       = (state_q == S_DONE);

endmodule
